// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, state type and round/sigma helpers for the nonce worker
package sha256_pkg;

  localparam int LEN_P2 = 640;
  localparam int LEN_P3 = 256;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] shr(input logic [31:0] x, input int n);
    return x >> n;
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

  // s is {a,b,c,d,e,f,g,h} with a in the MSBs; result uses the same packing
  function automatic logic [255:0] sha256_round(input logic [255:0] s, input logic [31:0] k,
                                                input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_nonce_worker_if.sv
// rtl/sha256_nonce_worker_if.sv - master/worker start/finish handshake and job data bundle
interface sha256_nonce_worker_if;
  logic         start;
  logic         phase_sel;
  logic [31:0]  nonce;
  logic [95:0]  msg_tail;
  logic [255:0] hin;
  logic [255:0] hout;
  logic         busy;
  logic         finish;

  modport master (
    output start, phase_sel, nonce, msg_tail, hin,
    input  hout, busy, finish
  );

  modport slave (
    input  start, phase_sel, nonce, msg_tail, hin,
    output hout, busy, finish
  );
endinterface

// File: rtl/sha256_msg_window.sv
// rtl/sha256_msg_window.sv - 16-word SHA-256 message schedule window with in-place expansion
// SHA_DUAL_ROUND_EN: shift by two words per cycle and expose a second word on w1.
module sha256_msg_window
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output logic [31:0]  w0
`ifdef SHA_DUAL_ROUND_EN
  ,
  output logic [31:0]  w1
`endif
);

  logic [31:0] win [16];
  logic [31:0] nxt0;

  assign nxt0 = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign w0   = win[0];

`ifdef SHA_DUAL_ROUND_EN
  // Second new word only reaches back to win[15], never to nxt0, so both compute in parallel
  logic [31:0] nxt1;
  assign nxt1 = sig1(win[15]) + win[10] + sig0(win[2]) + win[1];
  assign w1   = win[1];
`endif

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block[511 - 32*i -: 32];
    end else if (shift) begin
`ifdef SHA_DUAL_ROUND_EN
      for (int i = 0; i < 14; i++) win[i] <= win[i + 2];
      win[14] <= nxt0;
      win[15] <= nxt1;
`else
      for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
      win[15] <= nxt0;
`endif
    end
  end

endmodule

// File: rtl/sha256_nonce_worker.sv
// rtl/sha256_nonce_worker.sv - per-nonce SHA-256 worker running phase-2 and phase-3 blocks
// SHA_DUAL_ROUND_EN: two chained rounds per cycle, halving the ROUND duration.
module sha256_nonce_worker
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
)(
  input logic                   clk,
  input logic                   reset,
  sha256_nonce_worker_if.slave  bus
);

  state_t       state;
  logic [5:0]   t;
  logic         phase_q;
  logic [255:0] st;
  logic [255:0] chain;
  logic [255:0] p2_dig;
  logic [255:0] st_next;
  logic [511:0] block;
  logic [31:0]  w0;
  logic         load;
  logic         shift;

  assign load  = (state == IDLE) && bus.start;
  assign shift = (state == ROUND);

  always_comb begin
    block = '0;
    if (bus.phase_sel)
      block = {p2_dig, 32'h8000_0000, 160'd0, 32'd0, 32'(LEN_P3)};
    else
      block = {bus.msg_tail, bus.nonce, 32'h8000_0000, 288'd0, 32'd0, 32'(LEN_P2)};
  end

`ifdef SHA_DUAL_ROUND_EN
  localparam logic [5:0] T_STEP = 6'd2;
  logic [31:0]  w1;
  logic [255:0] st_mid;

  assign st_mid  = sha256_round(st, K[t], w0);
  assign st_next = sha256_round(st_mid, K[t + 6'd1], w1);

  sha256_msg_window u_window (
    .clk   (clk),
    .load  (load),
    .shift (shift),
    .block (block),
    .w0    (w0),
    .w1    (w1)
  );
`else
  localparam logic [5:0] T_STEP = 6'd1;

  assign st_next = sha256_round(st, K[t], w0);

  sha256_msg_window u_window (
    .clk   (clk),
    .load  (load),
    .shift (shift),
    .block (block),
    .w0    (w0)
  );
`endif

  localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - int'(T_STEP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      t          <= '0;
      phase_q    <= 1'b0;
      st         <= '0;
      chain      <= '0;
      p2_dig     <= '0;
      bus.hout   <= '0;
      bus.busy   <= 1'b0;
      bus.finish <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            phase_q  <= bus.phase_sel;
            st       <= bus.phase_sel ? IV : bus.hin;
            chain    <= bus.phase_sel ? IV : bus.hin;
            t        <= '0;
            bus.busy <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          st <= st_next;
          t  <= t + T_STEP;
          if (t == T_LAST) state <= FINAL;
        end
        FINAL: begin
          // Stay in FINAL while finish is high so a start in that cycle is ignored
          if (!bus.finish) begin
            bus.hout   <= add_words(chain, st);
            if (!phase_q) p2_dig <= add_words(chain, st);
            bus.finish <= 1'b1;
          end else begin
            bus.finish <= 1'b0;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_worker.sv
// tb/tb_sha256_nonce_worker.sv - directed self-checking bench for sha256_nonce_worker
module tb_sha256_nonce_worker;

`ifdef SHA_DUAL_ROUND_EN
  localparam int FIN_LAT = 33;
`else
  localparam int FIN_LAT = 65;
`endif
  localparam int PULSE2 = (FIN_LAT > 40) ? 40 : 20;

  localparam logic [255:0] RIV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ZERO_DIG = 256'h66687aad_f862bd77_6c8fc18b_8e9f8e20_08971485_6ee233b3_902a591d_0d5f2925;

  localparam logic [31:0] RK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sha256_nonce_worker_if bus ();

  sha256_nonce_worker #(.NUM_ROUNDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression with a full 64-word schedule
  function automatic logic [255:0] ref_compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = hv;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + RK[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[255:224] + a, hv[223:192] + b, hv[191:160] + c, hv[159:128] + d,
            hv[127:96] + e, hv[95:64] + f, hv[63:32] + g, hv[31:0] + h};
  endfunction

  function automatic logic [511:0] p2_blk(input logic [95:0] tl, input logic [31:0] nc);
    return {tl, nc, 32'h8000_0000, 320'd0, 32'h0000_0280};
  endfunction

  function automatic logic [511:0] p3_blk(input logic [255:0] dg);
    return {dg, 32'h8000_0000, 192'd0, 32'h0000_0100};
  endfunction

  task automatic run_job(input logic ph, input logic [31:0] nc, input logic [95:0] tl,
                         input logic [255:0] hv, input bit scramble, output int lat);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.phase_sel = ph;
    bus.nonce     = nc;
    bus.msg_tail  = tl;
    bus.hin       = hv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 256'(bus.busy), 256'd1);
    lat = 0;
    while (!bus.finish && lat < 200) begin
      if (scramble) begin
        bus.nonce     = $urandom;
        bus.msg_tail  = {$urandom, $urandom, $urandom};
        bus.hin       = {8{$urandom}};
        bus.phase_sel = ~ph;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int nfin;
    int first;
    logic [255:0] exp_p2;
    logic [255:0] hv_pat;
    logic [95:0]  tl_pat;
    logic [31:0]  nc_pat;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.phase_sel = 1'b0;
    bus.nonce = '0;
    bus.msg_tail = '0;
    bus.hin = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hout", bus.hout, 256'd0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_finish", 256'(bus.finish), 256'd0);
    reset = 1'b0;

    // Phase 3 with cleared p2_dig: SHA-256 of 32 zero bytes
    run_job(1'b1, 32'd0, 96'd0, 256'd0, 1'b0, lat);
    check("p3_zero_lat", 256'(lat), 256'(FIN_LAT));
    check("p3_zero_hout", bus.hout, ZERO_DIG);
    check("p3_zero_busy_fin", 256'(bus.busy), 256'd1);
    @(posedge clk); #1;
    check("p3_zero_busy_drop", 256'(bus.busy), 256'd0);
    check("p3_zero_fin_drop", 256'(bus.finish), 256'd0);
    check("p3_zero_hold", bus.hout, ZERO_DIG);

    // Phase 2 from IV with all-zero tail and nonce, then phase 3 at the earliest restart
    exp_p2 = ref_compress(RIV, p2_blk(96'd0, 32'd0));
    run_job(1'b0, 32'd0, 96'd0, RIV, 1'b0, lat);
    check("p2_iv_lat", 256'(lat), 256'(FIN_LAT));
    check("p2_iv_hout", bus.hout, exp_p2);
    run_job(1'b1, 32'hffff_ffff, 96'd0, 256'd0, 1'b0, lat);
    check("p3_chain_lat", 256'(lat), 256'(FIN_LAT));
    check("p3_chain_hout", bus.hout, ref_compress(RIV, p3_blk(exp_p2)));

    // Inputs scrambled every cycle after start must not affect the job
    hv_pat = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
    tl_pat = 96'hdeadbeef_cafef00d_13579bdf;
    nc_pat = 32'h2468ace0;
    exp_p2 = ref_compress(hv_pat, p2_blk(tl_pat, nc_pat));
    run_job(1'b0, nc_pat, tl_pat, hv_pat, 1'b1, lat);
    check("p2_scr_lat", 256'(lat), 256'(FIN_LAT));
    check("p2_scr_hout", bus.hout, exp_p2);
    run_job(1'b1, nc_pat, tl_pat, hv_pat, 1'b1, lat);
    check("p3_scr_hout", bus.hout, ref_compress(RIV, p3_blk(exp_p2)));
    run_job(1'b1, 32'd0, 96'd0, 256'd0, 1'b0, lat);
    check("p3_repeat_hout", bus.hout, ref_compress(RIV, p3_blk(exp_p2)));

    // Start pulses while busy and during the finish cycle are ignored
    tl_pat = 96'h01020304_05060708_090a0b0c;
    nc_pat = 32'h1234_5678;
    exp_p2 = ref_compress(RIV, p2_blk(tl_pat, nc_pat));
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.phase_sel = 1'b0;
    bus.nonce = nc_pat;
    bus.msg_tail = tl_pat;
    bus.hin = RIV;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.phase_sel = 1'b1;
    bus.nonce = 32'h0bad_0bad;
    bus.msg_tail = 96'h1;
    bus.hin = 256'h5;
    cnt = 0;
    nfin = 0;
    first = 0;
    while (cnt < 120) begin
      @(posedge clk); #1;
      cnt++;
      bus.start = 1'b0;
      if (bus.finish) begin
        nfin++;
        if (first == 0) first = cnt;
      end
      if (cnt == 10 || cnt == PULSE2 || bus.finish) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    check("pulse_fin_count", 256'(nfin), 256'd1);
    check("pulse_fin_cycle", 256'(first), 256'(FIN_LAT));
    check("pulse_hout", bus.hout, exp_p2);
    check("pulse_idle", 256'(bus.busy), 256'd0);

    // Asynchronous reset mid-job clears outputs and p2_dig
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.phase_sel = 1'b0;
    bus.hin = RIV;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_hout", bus.hout, 256'd0);
    check("midrst_busy", 256'(bus.busy), 256'd0);
    check("midrst_finish", 256'(bus.finish), 256'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_job(1'b1, 32'd0, 96'd0, 256'd0, 1'b0, lat);
    check("postrst_lat", 256'(lat), 256'(FIN_LAT));
    check("postrst_hout", bus.hout, ZERO_DIG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_worker.md
Name: sha256_nonce_worker

Overview:
- Responder side of the master-to-worker start/finish handshake used by the bitcoin hash master.
- Each instance hashes one nonce. It runs two jobs on request:
  - Phase 2: the second block of the 80-byte header, chained from the master's phase-1 midstate.
  - Phase 3: the double-hash block over its own phase-2 digest.
- Sixteen instances sit in parallel under the master. All start together and finish on the same cycle.

Parameters:
- NUM_ROUNDS, 64, SHA-256 rounds per block. Fixed by the algorithm; exposed only for bench shortening, and only 64 is legal in synthesis.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle job request from master; sampled only in IDLE.
- phase_sel  input  1  0 = phase 2, 1 = phase 3; sampled with start.
- nonce  input  32  header word 19; sampled with start.
- msg_tail  input  96  header words 16,17,18 packed {w16,w17,w18}; sampled with start.
- hin  input  256  chaining value {H0..H7}, H0 in [255:224]; used only in phase 2.
- hout  output  256  job digest {H0..H7}, H0 in MSBs; valid from the finish cycle and held until the next accepted start.
- busy  output  1  high from the cycle after an accepted start through the finish cycle.
- finish  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state, including mid-job):
  - State goes to IDLE; hout=0, busy=0, finish=0.
  - Stored phase-2 digest (p2_dig) is cleared to 0. Round registers are don't-care.
- State machine: IDLE -> ROUND -> FINAL -> IDLE.
- IDLE:
  - On start=1, latch phase_sel, nonce and msg_tail.
  - Load a..h and the chain register: from hin when phase 2; from the SHA-256 IV (6a09e667..5be0cd19) when phase 3.
  - Load the 16-word W window, then go to ROUND with t=0.
- Phase-2 block W[0..15]:
  - w16, w17, w18, nonce, 80000000h, then zeros for words 5..13.
  - W14=0, W15=00000280h (640 bits).
- Phase-3 block W[0..15]:
  - p2_dig H0..H7, 80000000h, then zeros for words 9..13.
  - W14=0, W15=00000100h (256 bits).
- ROUND:
  - One round per cycle using Wt = window[0].
  - Window shifts left by one and appends the expansion s1(W[14])+W[9]+s0(W[1])+W[0], all mod 2^32.
  - Leave ROUND after t=63.
- FINAL:
  - hout <= chain + {a..h}, word-wise mod 2^32. When phase 2, also p2_dig <= the same value.
  - finish <= 1 for exactly one cycle; busy drops in the cycle after finish.
- Latency: start sampled at edge N gives finish high during cycle N+65 to N+66 (rounds occupy edges N+1..N+64; FINAL registers at edge N+65).
- Boundaries and rules:
  - start while busy is ignored: no restart, no latch.
  - start in the same cycle finish is high is also ignored, because state is still FINAL. The earliest legal restart is the cycle after finish.
  - Inputs other than start may change freely after the start cycle.
  - phase_sel=1 with no prior phase 2 since reset hashes 32 zero bytes (p2_dig=0). This is legal and defined.
  - A phase-2 job overwrites p2_dig. A phase-3 job never modifies p2_dig.
  - All arithmetic is 32-bit unsigned with wrap; no overflow flags.

Optional Feature:
- Macro SHA_DUAL_ROUND_EN.
- Defined:
  - Two rounds per cycle (t, t+1 chained combinationally); the window shifts by two and appends two expanded words.
  - ROUND lasts 32 cycles, so finish arrives 34 cycles after the start edge.
- Undefined: one round per cycle, 66-cycle latency as above.
- Digests are identical in both builds.

Decomposition:
- Package sha256_pkg holds:
  - K[64] constant table and the IV[8] constant;
  - the state enum type (IDLE, ROUND, FINAL);
  - functions rotr, shr, sha256_round (returns packed {a..h}) and the s0/s1 expansion sigma;
  - length constants LEN_P2=640 and LEN_P3=256.
- One natural sub-module, sha256_msg_window: the 16-word shift window plus expansion, with load/shift ports. The worker FSM instantiates it.

Test Plan:
- Phase 3 straight after reset (p2_dig=0) -> hout = 66687aad f862bd77 6c8fc18b 8e9f8e20 08971485 6ee233b3 902a591d 0d5f2925; finish at start+66; busy for 66 cycles.
- Phase 2 with hin=IV, msg_tail=0, nonce=0, then phase 3 -> both digests match the C reference model. The phase-3 hout equals SHA256 of the phase-2 digest.
- Pulse start at cycles 10, 40 and the finish cycle of a running job -> exactly one job runs; finish occurs once; hout matches the first job.
- Change nonce and msg_tail every cycle after an accepted start -> hout matches the values latched at start.
- Assert reset at round 30 -> hout=0, busy=0, finish=0 at once. A new phase-3 job then yields the zero-digest result above, showing p2_dig was cleared.
- With SHA_DUAL_ROUND_EN defined, rerun the first two scenarios -> same digests; finish at start+34.
